// File: rtl/pci_to_rdmx.sv
// pci_to_rdmx: transmit-side bridge from the host-RAM buffer to RDMX packets.
// A command (offset, rdmx address, cycle count) is range-checked, turned into a
// single AXI4 INCR read burst, and the returned R beats are sent out on an
// AXI-stream behind one RDMX header cycle.
//
// Ports:
//   clk, resetn           clock, asynchronous active-low reset
//   pci_base, pci_size    host-RAM buffer window (bytes)
//   CMD_*                 command stream {cycles[135:128], rdmx_addr[127:64], pci_offset[63:0]}
//   pci_range_err_strb    pulse on a rejected command
//   rresp_err_strb        pulse on each accepted R beat with RRESP != 0
//   pci_throughput        R beats accepted in the last FREQ_HZ+1 cycle window
//   AXIS_OUT_*            RDMX packet stream (header, then payload)
//   M_AXI_AR*/R*          AXI4 read master; AW/W tied off, BREADY follows resetn
//
// Header layout (rdmx_encoder): [63:0] rdmx_address, [95:64] payload_bytes,
// all higher bits zero.
module pci_to_rdmx #(
    parameter int DW      = 512,
    parameter int FREQ_HZ = 250000000
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic [63:0]     pci_base,
    input  logic [63:0]     pci_size,
    input  logic [135:0]    CMD_TDATA,
    input  logic            CMD_TVALID,
    output logic            CMD_TREADY,
    output logic            pci_range_err_strb,
    output logic            rresp_err_strb,
    output logic [31:0]     pci_throughput,
    output logic [DW-1:0]   AXIS_OUT_TDATA,
    output logic            AXIS_OUT_TVALID,
    output logic            AXIS_OUT_TLAST,
    input  logic            AXIS_OUT_TREADY,
    output logic [63:0]     M_AXI_ARADDR,
    output logic [7:0]      M_AXI_ARLEN,
    output logic [2:0]      M_AXI_ARSIZE,
    output logic [1:0]      M_AXI_ARBURST,
    output logic [3:0]      M_AXI_ARID,
    output logic            M_AXI_ARLOCK,
    output logic [3:0]      M_AXI_ARCACHE,
    output logic [3:0]      M_AXI_ARQOS,
    output logic [2:0]      M_AXI_ARPROT,
    output logic            M_AXI_ARVALID,
    input  logic            M_AXI_ARREADY,
    input  logic [DW-1:0]   M_AXI_RDATA,
    input  logic [1:0]      M_AXI_RRESP,
    input  logic            M_AXI_RLAST,
    input  logic            M_AXI_RVALID,
    output logic            M_AXI_RREADY,
    output logic [3:0]      M_AXI_AWID,
    output logic [63:0]     M_AXI_AWADDR,
    output logic [7:0]      M_AXI_AWLEN,
    output logic [2:0]      M_AXI_AWSIZE,
    output logic [1:0]      M_AXI_AWBURST,
    output logic            M_AXI_AWLOCK,
    output logic [3:0]      M_AXI_AWCACHE,
    output logic [2:0]      M_AXI_AWPROT,
    output logic [3:0]      M_AXI_AWQOS,
    output logic            M_AXI_AWVALID,
    output logic [DW-1:0]   M_AXI_WDATA,
    output logic [DW/8-1:0] M_AXI_WSTRB,
    output logic            M_AXI_WLAST,
    output logic            M_AXI_WVALID,
    output logic            M_AXI_BREADY
);
    localparam int ASIZE = $clog2(DW / 8);

    typedef enum logic [1:0] {IDLE, ADDR, HDR, DATA} state_e;

    state_e      state_q;
    logic        cmd_rdy_q, arvalid_q, hdr_vld_q;
    logic [63:0] araddr_q, rdmx_q;
    logic [7:0]  arlen_q, cyc_q, beat_q;

    // Command decode and range check, evaluated in the accept cycle.
    logic [63:0] cmd_off, cmd_addr, cmd_pa;
    logic [7:0]  cmd_cyc;
    logic [13:0] cmd_bytes;
    logic [64:0] cmd_end;
    logic [14:0] cmd_pg_end;
    logic        cmd_bad, cmd_fire;

    assign cmd_off    = CMD_TDATA[63:0];
    assign cmd_addr   = CMD_TDATA[127:64];
    assign cmd_cyc    = CMD_TDATA[135:128];
    assign cmd_bytes  = {cmd_cyc, 6'b0};
    assign cmd_pa     = pci_base + cmd_off;
    // 65-bit sum so an offset near 2^64 cannot wrap past the size check.
    assign cmd_end    = {1'b0, cmd_off} + {51'b0, cmd_bytes};
    assign cmd_pg_end = {3'b0, cmd_pa[11:0]} + {1'b0, cmd_bytes};
    assign cmd_bad    = (cmd_cyc == 8'd0) || (cmd_end > {1'b0, pci_size}) ||
                        (cmd_pg_end > 15'd4096);
    assign cmd_fire   = CMD_TVALID & cmd_rdy_q;

    logic in_data, rready, r_fire;
    assign in_data = (state_q == DATA);
    assign rready  = in_data & AXIS_OUT_TREADY;
    assign r_fire  = M_AXI_RVALID & rready;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= IDLE;
            cmd_rdy_q <= 1'b0;
            arvalid_q <= 1'b0;
            hdr_vld_q <= 1'b0;
            araddr_q  <= '0;
            rdmx_q    <= '0;
            arlen_q   <= '0;
            cyc_q     <= '0;
            beat_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    cmd_rdy_q <= 1'b1;
                    if (cmd_fire && !cmd_bad) begin
                        araddr_q  <= cmd_pa;
                        arlen_q   <= cmd_cyc - 8'd1;
                        rdmx_q    <= cmd_addr;
                        cyc_q     <= cmd_cyc;
                        cmd_rdy_q <= 1'b0;
                        arvalid_q <= 1'b1;
                        state_q   <= ADDR;
                    end
                end
                ADDR: begin
                    if (M_AXI_ARREADY) begin
                        arvalid_q <= 1'b0;
                        hdr_vld_q <= 1'b1;
                        state_q   <= HDR;
                    end
                end
                HDR: begin
                    if (AXIS_OUT_TREADY) begin
                        hdr_vld_q <= 1'b0;
                        beat_q    <= 8'd1;
                        state_q   <= DATA;
                    end
                end
                DATA: begin
                    // Packet end is counted locally; RLAST is not trusted.
                    if (r_fire) begin
                        if (beat_q == cyc_q) begin
                            state_q   <= IDLE;
                            cmd_rdy_q <= 1'b1;
                        end else begin
                            beat_q <= beat_q + 8'd1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Throughput window: FREQ_HZ+1 cycles; a beat in the reload cycle opens the next window.
    logic [31:0] tp_cnt_q, tp_cnt_d, tp_beats_q, tp_beats_d, tp_q, tp_d;

    always_comb begin
        tp_cnt_d   = tp_cnt_q - 32'd1;
        tp_beats_d = tp_beats_q + {31'b0, r_fire};
        tp_d       = tp_q;
        if (tp_cnt_q == 32'd0) begin
            tp_cnt_d   = 32'(FREQ_HZ);
            tp_d       = tp_beats_q;
            tp_beats_d = {31'b0, r_fire};
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tp_cnt_q   <= 32'(FREQ_HZ);
            tp_beats_q <= '0;
            tp_q       <= '0;
        end else begin
            tp_cnt_q   <= tp_cnt_d;
            tp_beats_q <= tp_beats_d;
            tp_q       <= tp_d;
        end
    end

    logic [DW-1:0] hdr_data;
    always_comb begin
        hdr_data         = '0;
        hdr_data[63:0]   = rdmx_q;
        hdr_data[95:64]  = {18'b0, cyc_q, 6'b0};
        AXIS_OUT_TDATA   = '0;
        if (hdr_vld_q)    AXIS_OUT_TDATA = hdr_data;
        else if (in_data) AXIS_OUT_TDATA = M_AXI_RDATA;
    end

    logic unused_rlast;
    assign unused_rlast = M_AXI_RLAST;

    assign CMD_TREADY         = cmd_rdy_q;
    assign pci_range_err_strb = cmd_fire & cmd_bad;
    assign rresp_err_strb     = r_fire & (M_AXI_RRESP != 2'b00);
    assign pci_throughput     = tp_q;
    assign AXIS_OUT_TVALID    = hdr_vld_q | (in_data & M_AXI_RVALID);
    assign AXIS_OUT_TLAST     = in_data & (beat_q == cyc_q);

    assign M_AXI_ARADDR  = araddr_q;
    assign M_AXI_ARLEN   = arlen_q;
    assign M_AXI_ARSIZE  = arvalid_q ? 3'(ASIZE) : 3'd0;
    assign M_AXI_ARBURST = arvalid_q ? 2'b01 : 2'b00;
    assign M_AXI_ARID    = '0;
    assign M_AXI_ARLOCK  = 1'b0;
    assign M_AXI_ARCACHE = '0;
    assign M_AXI_ARQOS   = '0;
    assign M_AXI_ARPROT  = '0;
    assign M_AXI_ARVALID = arvalid_q;
    assign M_AXI_RREADY  = rready;

    assign M_AXI_AWID    = '0;
    assign M_AXI_AWADDR  = '0;
    assign M_AXI_AWLEN   = '0;
    assign M_AXI_AWSIZE  = '0;
    assign M_AXI_AWBURST = '0;
    assign M_AXI_AWLOCK  = 1'b0;
    assign M_AXI_AWCACHE = '0;
    assign M_AXI_AWPROT  = '0;
    assign M_AXI_AWQOS   = '0;
    assign M_AXI_AWVALID = 1'b0;
    assign M_AXI_WDATA   = '0;
    assign M_AXI_WSTRB   = '0;
    assign M_AXI_WLAST   = 1'b0;
    assign M_AXI_WVALID  = 1'b0;
    assign M_AXI_BREADY  = resetn;
endmodule
